// File: rtl/gray_pkg.sv
// gray_pkg: mode encoding and width-independent Gray/binary conversion helpers.
package gray_pkg;
  typedef enum logic {MODE_G2B = 1'b0, MODE_B2G = 1'b1} mode_e;
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;
  // Callers zero-extend into word_t; zero upper bits leave the low WIDTH bits exact.
  function automatic word_t g2b(input word_t g);
    word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic word_t b2g(input word_t b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_step_check.sv
// gray_step_check: flags a word pair that differs in more than one bit.
module gray_step_check #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] last,
  output logic             multi
);
  logic [WIDTH-1:0] d;
  assign d = cur ^ last;
  // Clearing the lowest set bit leaves something only if two or more bits differ.
  assign multi = |(d & (d - WIDTH'(1)));
endmodule

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: two-stage valid/ready Gray<->binary converter with G2B step checking.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_step_err,
  output logic [CNT_W-1:0] err_cnt
);
  logic             s1_valid, s1_mode, s1_err;
  logic             s2_valid, s2_mode, s2_err;
  logic [WIDTH-1:0] s1_data, s2_data, last, conv;
  logic             last_valid, multi, s2_adv, s1_adv, accept, flag;

  gray_step_check #(.WIDTH(WIDTH)) u_step (
    .cur  (in_data),
    .last (last),
    .multi(multi)
  );

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;
  assign flag     = (in_mode == MODE_G2B) && last_valid && multi;
  assign conv     = (s1_mode == MODE_B2G) ? WIDTH'(b2g(word_t'(s1_data)))
                                          : WIDTH'(g2b(word_t'(s1_data)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_mode    <= 1'b0;
      s1_err     <= 1'b0;
      last       <= '0;
      last_valid <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (accept) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
        s1_err  <= flag;
        // A B2G beat breaks the G2B sequence, so the next G2B beat starts fresh.
        last_valid <= (in_mode == MODE_G2B);
        if (in_mode == MODE_G2B) last <= in_data;
        if (flag && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_mode  <= 1'b0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= conv;
        s2_mode <= s1_mode;
        s2_err  <= s1_err;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign out_data     = s2_data;
  assign out_mode     = s2_mode;
  assign out_step_err = s2_err;
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: table vectors, stall/reset sequences and random traffic against a queue model.
module tb_gray_codec_pipe;
  localparam int W = 4;
  localparam int CW = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, out_mode, out_step_err;
  logic [W-1:0]  out_data;
  logic [CW-1:0] err_cnt;

  gray_codec_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .out_step_err(out_step_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, n_acc = 0, n_del = 0;

  typedef struct packed {logic [W-1:0] d; logic m; logic e;} beat_t;
  beat_t q[$];
  logic [W-1:0] m_last = '0;
  logic         m_lv = 1'b0;
  int           m_cnt = 0;
  logic         hold = 1'b0, h_mode, h_err;
  logic [W-1:0] h_data;

  typedef struct packed {logic m; logic [W-1:0] d; logic [W-1:0] e; logic err; logic [CW-1:0] cnt;} vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Binary bit i of a Gray word is the parity of all Gray bits at or above i.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ($countones(g >> i) % 2) == 1;
    return b;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always @(negedge clk) begin
    beat_t e, o;
    if (!rst_n) begin
      q.delete();
      m_lv  = 1'b0;
      m_cnt = 0;
      hold  = 1'b0;
    end else begin
      chk("err_cnt", 32'(err_cnt), m_cnt);
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2 || out_ready));
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(h_data));
        chk("hold_mode", 32'(out_mode), 32'(h_mode));
        chk("hold_err", 32'(out_step_err), 32'(h_err));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          o = q.pop_front();
          chk("sb_data", 32'(out_data), 32'(o.d));
          chk("sb_mode", 32'(out_mode), 32'(o.m));
          chk("sb_err", 32'(out_step_err), 32'(o.e));
        end
        n_del++;
      end
      hold   = out_valid && !out_ready;
      h_data = out_data;
      h_mode = out_mode;
      h_err  = out_step_err;
      if (in_valid && in_ready) begin
        e.m = in_mode;
        e.d = in_mode ? ref_b2g(in_data) : ref_g2b(in_data);
        e.e = !in_mode && m_lv && ($countones(in_data ^ m_last) > 1);
        q.push_back(e);
        if (e.e && m_cnt < 255) m_cnt++;
        if (in_mode) m_lv = 1'b0;
        else begin
          m_lv   = 1'b1;
          m_last = in_data;
        end
        n_acc++;
      end
    end
  end

  task automatic send(input logic m, input logic [W-1:0] d);
    int t;
    logic done;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    t = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else if (++t > 50) begin
        chk("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] st[3];
    int k, n0;
    logic took, seen;
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0001, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 4'b0011, 4'b0010, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 4'b0010, 4'b0011, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 4'b0011, 4'b0010, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 4'b0110, 4'b0100, 1'b1, 8'd1};
    tbl[6]  = '{1'b1, 4'b1001, 4'b1101, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 4'b1101, 4'b1001, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 4'b1101, 4'b1001, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 4'b0101, 4'b0110, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 8'd2};
    tbl[11] = '{1'b0, 4'b1000, 4'b1111, 1'b0, 8'd2};
    tbl[12] = '{1'b1, 4'b1111, 4'b1000, 1'b0, 8'd2};
    tbl[13] = '{1'b0, 4'b0111, 4'b0101, 1'b0, 8'd2};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_mode", 32'(out_mode), 0);
    chk("rst_out_err", 32'(out_step_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      send(tbl[i].m, tbl[i].d);
      @(negedge clk);
      chk("lat_early_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 1);
      chk("vec_data", 32'(out_data), 32'(tbl[i].e));
      chk("vec_mode", 32'(out_mode), 32'(tbl[i].m));
      chk("vec_err", 32'(out_step_err), 32'(tbl[i].err));
      chk("vec_cnt", 32'(err_cnt), 32'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end

    st[0] = 4'b0110;
    st[1] = 4'b0010;
    st[2] = 4'b0011;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = st[0];
    k = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 6) begin
        chk("stall_accepted", k, 2);
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_out_data", 32'(out_data), 32'(4'b0100));
        n0 = n_del;
        out_ready = 1'b1;
      end
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        k++;
        if (k < 3) in_data = st[k];
        else in_valid = 1'b0;
      end
    end
    chk("stall_all_accepted", k, 3);
    chk("stall_delivered", n_del - n0, 3);

    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_mode   = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
    chk("acc_eq_del", n_acc, n_del);

    in_valid = 1'b1;
    in_mode  = 1'b0;
    for (int i = 0; i < 302; i++) begin
      in_data = (i % 2 == 1) ? 4'b1111 : 4'b0000;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("err_saturated", 32'(err_cnt), 255);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = 4'b0101;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_in_ready", 32'(in_ready), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_err_cnt", 32'(err_cnt), 0);
    chk("async_in_ready", 32'(in_ready), 1);
    chk("async_out_data", 32'(out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 4'b0011);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("post_rst_seen", 32'(seen), 1);
    chk("post_rst_data", 32'(out_data), 32'(4'b0010));
    chk("post_rst_err", 32'(out_step_err), 0);
    chk("post_rst_cnt", 32'(err_cnt), 0);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gray_codec_pipe.md
GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the data word width; legal range is WIDTH >= 2.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the error counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  an input beat is present.
REQ-006 SHALL have port in_ready  output  1  the block accepts the beat this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  the word to convert.
REQ-008 SHALL have port in_mode  input  1  0 = gray-to-binary (G2B), 1 = binary-to-gray (B2G); selected per beat.
REQ-009 SHALL have port out_valid  output  1  a result beat is present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_data  output  WIDTH  the converted word.
REQ-012 SHALL have port out_mode  output  1  the mode that travelled with the beat.
REQ-013 SHALL have port out_step_err  output  1  the beat violated the single-bit-step rule (G2B beats only).
REQ-014 SHALL have port err_cnt  output  CNT_W  saturating count of step errors.

Function
REQ-015 A beat SHALL be accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
REQ-016 The pipeline SHALL have two register stages: S1 holds the input word, mode and step flag; S2 holds the converted result.
REQ-017 Latency SHALL be 2 cycles from acceptance to out_valid when there is no stall; throughput SHALL be 1 beat per cycle.
REQ-018 S2 SHALL advance when (!s2_valid || out_ready); S1 SHALL advance when S2 advances or S1 is empty.
REQ-019 in_ready SHALL be (!s1_valid || S2 advances), and SHALL NOT depend combinationally on in_valid.
REQ-020 During a stall, out_data, out_mode and out_step_err SHALL stay stable while out_valid = 1.
REQ-021 G2B conversion SHALL compute b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i] for i down to 0.
REQ-022 B2G conversion SHALL compute g = b ^ (b >> 1).
REQ-023 Step check, G2B beats only: the block SHALL keep the last accepted G2B word plus a last_valid flag, and SHALL flag the beat when popcount(cur ^ last) > 1.
REQ-024 A difference of 0 or 1 bits SHALL be legal.
REQ-025 No step check SHALL be made on the first G2B beat after reset, or on the first G2B beat after any B2G beat.
REQ-026 Every accepted B2G beat SHALL clear last_valid.
REQ-027 out_step_err SHALL always be 0 for B2G beats.
REQ-028 err_cnt SHALL increment when a flagged beat is accepted at the input, and SHALL saturate at all-ones with no wrap.
REQ-029 Wrap-around in the step check SHALL be legal: for WIDTH=4, 1000 following 0000 is a single-bit step.

Reset
REQ-030 When rst_n = 0, the block SHALL asynchronously clear s1_valid, s2_valid, last_valid, all data registers and err_cnt.
REQ-031 After such a reset, out_valid SHALL be 0, in_ready SHALL be 1, and out_data, out_mode and out_step_err SHALL be 0.
REQ-032 A reset applied mid-stream SHALL discard in-flight beats with no partial output.
REQ-033 Reset release SHALL be used synchronously.

Structure
REQ-034 A shared package gray_pkg SHALL hold the mode constants MODE_G2B = 0 and MODE_B2G = 1, plus parametrised-width conversion functions g2b and b2g.
REQ-035 A single combinational sub-module gray_step_check SHALL compute the popcount > 1 comparison for one word pair.

Verification (WIDTH=4)
REQ-036 Stream G2B 0000, 0001, 0011, 0010 -> outputs 0000, 0001, 0010, 0011, each 2 cycles after acceptance, with no step errors.
REQ-037 G2B 0011 followed by 0110 -> second beat gives out_data 0100 with out_step_err = 1, and err_cnt goes to 1.
REQ-038 B2G 1001 -> 1101; then G2B 1101 -> 1001 with no step check, because last_valid was cleared.
REQ-039 Hold out_ready = 0 and offer 3 beats -> 2 are accepted, in_ready = 0 on the third, outputs are stable; raise out_ready -> in-order delivery with no loss or duplication.
REQ-040 Apply 300 forced step errors with CNT_W = 8 -> err_cnt holds at 255.
REQ-041 Assert rst_n low with both stages full -> out_valid = 0 and err_cnt = 0 immediately; after release, the first G2B beat is unchecked.
